// File: rtl/tl_ul_channel_buffer.sv
// TileLink-UL A/D channel buffer: one independently sized FIFO per channel,
// with optional empty-bypass (flow) and full pass-through (pipe) behaviour.

module tl_ul_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   parameter int FLOW  = 0,
   parameter int PIPE  = 0,
   parameter int CNT_W = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [W-1:0]     enq_bits,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [W-1:0]     deq_bits,
   output logic [CNT_W-1:0] count
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign enq_ready = deq_ready;
         assign deq_valid = enq_valid;
         assign deq_bits  = enq_bits;
         assign count     = '0;
      end else begin : g_fifo
         localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

         logic [PTR_W-1:0] enq_ptr_q, enq_ptr_d;
         logic [PTR_W-1:0] deq_ptr_q, deq_ptr_d;
         logic             maybe_full_q, maybe_full_d;
         logic [CNT_W-1:0] count_q, count_d;
         logic [W-1:0]     mem_q [DEPTH];
         logic             ptr_match, empty, full, bypass, do_enq, do_deq;

         function automatic logic [PTR_W-1:0] ptr_incr(input logic [PTR_W-1:0] p);
            return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
         endfunction

         assign ptr_match = (enq_ptr_q == deq_ptr_q);
         assign empty     = ptr_match && !maybe_full_q;
         assign full      = ptr_match && maybe_full_q;
         assign bypass    = (FLOW != 0) && empty;

         assign enq_ready = !full || ((PIPE != 0) && deq_ready);
         assign deq_valid = !empty || ((FLOW != 0) && enq_valid);
         assign deq_bits  = bypass ? enq_bits : mem_q[deq_ptr_q];

         // A bypassed beat is consumed directly and never touches storage.
         assign do_enq = enq_valid && enq_ready && !(bypass && deq_ready);
         assign do_deq = deq_ready && !empty;

         always_comb begin
            enq_ptr_d    = enq_ptr_q;
            deq_ptr_d    = deq_ptr_q;
            maybe_full_d = maybe_full_q;
            count_d      = count_q;
            if (do_enq) enq_ptr_d = ptr_incr(enq_ptr_q);
            if (do_deq) deq_ptr_d = ptr_incr(deq_ptr_q);
            if (do_enq != do_deq) maybe_full_d = do_enq;
            if (do_enq && !do_deq)      count_d = count_q + CNT_W'(1);
            else if (do_deq && !do_enq) count_d = count_q - CNT_W'(1);
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               enq_ptr_q    <= '0;
               deq_ptr_q    <= '0;
               maybe_full_q <= 1'b0;
               count_q      <= '0;
            end else begin
               enq_ptr_q    <= enq_ptr_d;
               deq_ptr_q    <= deq_ptr_d;
               maybe_full_q <= maybe_full_d;
               count_q      <= count_d;
            end
         end

         always_ff @(posedge clock) begin
            if (do_enq) mem_q[enq_ptr_q] <= enq_bits;
         end

         assign count = count_q;
      end
   endgenerate

endmodule

module tl_ul_channel_buffer #(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 32,
   parameter int SRC_W   = 5,
   parameter int SIZE_W  = 3,
   parameter int SINK_W  = 1,
   parameter int A_DEPTH = 2,
   parameter int D_DEPTH = 2,
   parameter int A_FLOW  = 0,
   parameter int D_FLOW  = 0,
   parameter int A_PIPE  = 0,
   parameter int D_PIPE  = 0,
   localparam int A_CW   = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
   localparam int D_CW   = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_a_valid,
   output logic                in_a_ready,
   input  logic [2:0]          in_a_opcode,
   input  logic [2:0]          in_a_param,
   input  logic [SIZE_W-1:0]   in_a_size,
   input  logic [SRC_W-1:0]    in_a_source,
   input  logic [ADDR_W-1:0]   in_a_address,
   input  logic [DATA_W/8-1:0] in_a_mask,
   input  logic [DATA_W-1:0]   in_a_data,
   input  logic                in_a_corrupt,
   output logic                out_a_valid,
   input  logic                out_a_ready,
   output logic [2:0]          out_a_opcode,
   output logic [2:0]          out_a_param,
   output logic [SIZE_W-1:0]   out_a_size,
   output logic [SRC_W-1:0]    out_a_source,
   output logic [ADDR_W-1:0]   out_a_address,
   output logic [DATA_W/8-1:0] out_a_mask,
   output logic [DATA_W-1:0]   out_a_data,
   output logic                out_a_corrupt,
   input  logic                out_d_valid,
   output logic                out_d_ready,
   input  logic [2:0]          out_d_opcode,
   input  logic [1:0]          out_d_param,
   input  logic [SIZE_W-1:0]   out_d_size,
   input  logic [SRC_W-1:0]    out_d_source,
   input  logic [SINK_W-1:0]   out_d_sink,
   input  logic                out_d_denied,
   input  logic [DATA_W-1:0]   out_d_data,
   input  logic                out_d_corrupt,
   output logic                in_d_valid,
   input  logic                in_d_ready,
   output logic [2:0]          in_d_opcode,
   output logic [1:0]          in_d_param,
   output logic [SIZE_W-1:0]   in_d_size,
   output logic [SRC_W-1:0]    in_d_source,
   output logic [SINK_W-1:0]   in_d_sink,
   output logic                in_d_denied,
   output logic [DATA_W-1:0]   in_d_data,
   output logic                in_d_corrupt,
   output logic [A_CW-1:0]     a_count,
   output logic [D_CW-1:0]     d_count,
   output logic                busy
);

   localparam int A_W = 3 + 3 + SIZE_W + SRC_W + ADDR_W + DATA_W/8 + DATA_W + 1;
   localparam int D_W = 3 + 2 + SIZE_W + SRC_W + SINK_W + 1 + DATA_W + 1;

   logic [A_W-1:0] a_enq_bits, a_deq_bits;
   logic [D_W-1:0] d_enq_bits, d_deq_bits;

   assign a_enq_bits = {in_a_opcode, in_a_param, in_a_size, in_a_source,
                        in_a_address, in_a_mask, in_a_data, in_a_corrupt};
   assign {out_a_opcode, out_a_param, out_a_size, out_a_source,
           out_a_address, out_a_mask, out_a_data, out_a_corrupt} = a_deq_bits;

   assign d_enq_bits = {out_d_opcode, out_d_param, out_d_size, out_d_source,
                        out_d_sink, out_d_denied, out_d_data, out_d_corrupt};
   assign {in_d_opcode, in_d_param, in_d_size, in_d_source,
           in_d_sink, in_d_denied, in_d_data, in_d_corrupt} = d_deq_bits;

   tl_ul_fifo #(.W(A_W), .DEPTH(A_DEPTH), .FLOW(A_FLOW), .PIPE(A_PIPE), .CNT_W(A_CW)) u_a_fifo (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (in_a_valid),
      .enq_ready (in_a_ready),
      .enq_bits  (a_enq_bits),
      .deq_valid (out_a_valid),
      .deq_ready (out_a_ready),
      .deq_bits  (a_deq_bits),
      .count     (a_count)
   );

   tl_ul_fifo #(.W(D_W), .DEPTH(D_DEPTH), .FLOW(D_FLOW), .PIPE(D_PIPE), .CNT_W(D_CW)) u_d_fifo (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (out_d_valid),
      .enq_ready (out_d_ready),
      .enq_bits  (d_enq_bits),
      .deq_valid (in_d_valid),
      .deq_ready (in_d_ready),
      .deq_bits  (d_deq_bits),
      .count     (d_count)
   );

   assign busy = (a_count != '0) || (d_count != '0);

endmodule

// File: tb/tb_tl_ul_channel_buffer.sv
// Bench for tl_ul_channel_buffer: three configurations share one stimulus set;
// directed steps plus a randomized D-channel run against a queue model.

module tb_tl_ul_channel_buffer;

   logic        clock, reset;
   logic        in_a_valid, in_a_corrupt, out_a_ready;
   logic [2:0]  in_a_opcode, in_a_param, in_a_size;
   logic [4:0]  in_a_source;
   logic [13:0] in_a_address;
   logic [3:0]  in_a_mask;
   logic [31:0] in_a_data;
   logic        out_d_valid, out_d_denied, out_d_corrupt, in_d_ready;
   logic [2:0]  out_d_opcode, out_d_size;
   logic [1:0]  out_d_param;
   logic [4:0]  out_d_source;
   logic [0:0]  out_d_sink;
   logic [31:0] out_d_data;

   logic        ia_ready [3], oa_valid [3], oa_corrupt [3];
   logic [2:0]  oa_opcode [3], oa_param [3], oa_size [3];
   logic [4:0]  oa_source [3];
   logic [13:0] oa_address [3];
   logic [3:0]  oa_mask [3];
   logic [31:0] oa_data [3];
   logic        od_ready [3], id_valid [3], id_denied [3], id_corrupt [3];
   logic [2:0]  id_opcode [3], id_size [3];
   logic [1:0]  id_param [3];
   logic [4:0]  id_source [3];
   logic [0:0]  id_sink [3];
   logic [31:0] id_data [3];
   logic [1:0]  a_cnt [3], d_cnt [3];
   logic        busy [3];

   int checks = 0;
   int failures = 0;

   // Instance 0: A depth 2, D depth 3. Instance 1: A flow depth 2, D pipe depth 1.
   // Instance 2: both channels depth 0.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int AD  = (g == 0) ? 2 : (g == 1) ? 2 : 0;
      localparam int DD  = (g == 0) ? 3 : (g == 1) ? 1 : 0;
      localparam int AF  = (g == 1) ? 1 : 0;
      localparam int DP  = (g == 1) ? 1 : 0;
      localparam int ACW = (AD == 0) ? 1 : $clog2(AD + 1);
      localparam int DCW = (DD == 0) ? 1 : $clog2(DD + 1);
      logic [ACW-1:0] ac;
      logic [DCW-1:0] dc;
      assign a_cnt[g] = 2'(ac);
      assign d_cnt[g] = 2'(dc);

      tl_ul_channel_buffer #(
         .A_DEPTH(AD), .D_DEPTH(DD), .A_FLOW(AF), .D_FLOW(0), .A_PIPE(0), .D_PIPE(DP)
      ) dut (
         .clock(clock), .reset(reset),
         .in_a_valid(in_a_valid), .in_a_ready(ia_ready[g]),
         .in_a_opcode(in_a_opcode), .in_a_param(in_a_param), .in_a_size(in_a_size),
         .in_a_source(in_a_source), .in_a_address(in_a_address), .in_a_mask(in_a_mask),
         .in_a_data(in_a_data), .in_a_corrupt(in_a_corrupt),
         .out_a_valid(oa_valid[g]), .out_a_ready(out_a_ready),
         .out_a_opcode(oa_opcode[g]), .out_a_param(oa_param[g]), .out_a_size(oa_size[g]),
         .out_a_source(oa_source[g]), .out_a_address(oa_address[g]), .out_a_mask(oa_mask[g]),
         .out_a_data(oa_data[g]), .out_a_corrupt(oa_corrupt[g]),
         .out_d_valid(out_d_valid), .out_d_ready(od_ready[g]),
         .out_d_opcode(out_d_opcode), .out_d_param(out_d_param), .out_d_size(out_d_size),
         .out_d_source(out_d_source), .out_d_sink(out_d_sink), .out_d_denied(out_d_denied),
         .out_d_data(out_d_data), .out_d_corrupt(out_d_corrupt),
         .in_d_valid(id_valid[g]), .in_d_ready(in_d_ready),
         .in_d_opcode(id_opcode[g]), .in_d_param(id_param[g]), .in_d_size(id_size[g]),
         .in_d_source(id_source[g]), .in_d_sink(id_sink[g]), .in_d_denied(id_denied[g]),
         .in_d_data(id_data[g]), .in_d_corrupt(id_corrupt[g]),
         .a_count(ac), .d_count(dc), .busy(busy[g])
      );
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      in_a_valid = 0; in_a_opcode = 0; in_a_param = 0; in_a_size = 0; in_a_source = 0;
      in_a_address = 0; in_a_mask = 0; in_a_data = 0; in_a_corrupt = 0; out_a_ready = 0;
      out_d_valid = 0; out_d_opcode = 0; out_d_param = 0; out_d_size = 0; out_d_source = 0;
      out_d_sink = 0; out_d_denied = 0; out_d_data = 0; out_d_corrupt = 0; in_d_ready = 0;
   endtask

   task automatic pulse_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic push_a2(input logic [13:0] a0, input logic [13:0] a1);
      out_a_ready = 0;
      in_a_valid = 1; in_a_address = a0;
      tick();
      in_a_address = a1;
      tick();
      in_a_valid = 0;
      #1;
   endtask

   logic [36:0] q [$];
   int sent, rcvd;

   initial begin
      reset = 1'b1;
      idle_inputs();
      #12 reset = 1'b0;
      @(negedge clock);
      #1;

      // Reset state on instance 0
      check("rst_in_a_ready", ia_ready[0], 1);
      check("rst_out_d_ready", od_ready[0], 1);
      check("rst_out_a_valid", oa_valid[0], 0);
      check("rst_in_d_valid", id_valid[0], 0);
      check("rst_a_count", a_cnt[0], 0);
      check("rst_d_count", d_cnt[0], 0);
      check("rst_busy", busy[0], 0);

      // A depth 2: fill with ready low, then drain in order
      push_a2(14'h010, 14'h020);
      check("a_full_ready", ia_ready[0], 0);
      check("a_full_count", a_cnt[0], 2);
      check("a_full_busy", busy[0], 1);
      check("a_head_valid", oa_valid[0], 1);
      out_a_ready = 1;
      #1;
      check("a_out0_addr", oa_address[0], 14'h010);
      tick();
      check("a_out1_valid", oa_valid[0], 1);
      check("a_out1_addr", oa_address[0], 14'h020);
      check("a_out1_count", a_cnt[0], 1);
      check("a_out1_ready", ia_ready[0], 1);
      tick();
      check("a_drained_valid", oa_valid[0], 0);
      check("a_drained_count", a_cnt[0], 0);

      // Asynchronous reset with two beats held
      push_a2(14'h111, 14'h222);
      check("a_pre_rst_count", a_cnt[0], 2);
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid", oa_valid[0], 0);
      check("async_rst_count", a_cnt[0], 0);
      check("async_rst_busy", busy[0], 0);
      check("async_rst_ready", ia_ready[0], 1);
      @(negedge clock);
      reset = 1'b0;
      idle_inputs();
      #1;

      // D depth 3, random handshakes, queue reference model
      pulse_reset();
      q.delete();
      sent = 0;
      rcvd = 0;
      for (int cyc = 0; cyc < 400 && rcvd < 7; cyc++) begin
         check("d_count", d_cnt[0], q.size());
         check("d_valid", id_valid[0], q.size() != 0);
         out_d_valid  = (sent < 7) && ($urandom_range(0, 3) != 0);
         out_d_data   = 32'(sent + 1);
         out_d_source = 5'($urandom);
         in_d_ready   = ($urandom_range(0, 2) != 0);
         #1;
         check("d_ready", od_ready[0], q.size() < 3);
         if (id_valid[0] && in_d_ready) begin
            if (q.size() != 0) begin
               check("d_beat", {id_source[0], id_data[0]}, q[0]);
               void'(q.pop_front());
            end else begin
               check("d_spurious_beat", 1, 0);
            end
            rcvd++;
         end
         if (out_d_valid && od_ready[0]) begin
            q.push_back({out_d_source, out_d_data});
            sent++;
         end
         tick();
      end
      check("d_all_received", rcvd, 7);
      idle_inputs();

      // A flow on instance 1: empty bypass in the same cycle
      pulse_reset();
      in_a_valid = 1; in_a_source = 5'h1F; in_a_address = 14'h3A5; out_a_ready = 1;
      #1;
      check("flow_valid", oa_valid[1], 1);
      check("flow_source", oa_source[1], 5'h1F);
      check("flow_address", oa_address[1], 14'h3A5);
      tick();
      check("flow_count", a_cnt[1], 0);
      out_a_ready = 0;
      tick();
      check("flow_stored_count", a_cnt[1], 1);
      check("flow_stored_source", oa_source[1], 5'h1F);

      // D pipe depth 1 on instance 1: full, enq accepted alongside deq
      pulse_reset();
      out_d_valid = 1; out_d_denied = 0; out_d_data = 32'hAA;
      tick();
      check("pipe_full_count", d_cnt[1], 1);
      check("pipe_full_ready", od_ready[1], 0);
      in_d_ready = 1; out_d_denied = 1; out_d_data = 32'hBB;
      #1;
      check("pipe_ready", od_ready[1], 1);
      check("pipe_old_denied", id_denied[1], 0);
      check("pipe_old_data", id_data[1], 32'hAA);
      tick();
      check("pipe_count", d_cnt[1], 1);
      check("pipe_new_denied", id_denied[1], 1);
      check("pipe_new_data", id_data[1], 32'hBB);
      out_d_valid = 0;
      tick();
      check("pipe_drained_count", d_cnt[1], 0);
      check("pipe_drained_valid", id_valid[1], 0);

      // Depth 0 on instance 2: combinational wires
      pulse_reset();
      for (int i = 0; i < 16; i++) begin
         in_a_valid = 1'($urandom); in_a_opcode = 3'($urandom); in_a_param = 3'($urandom);
         in_a_size = 3'($urandom); in_a_source = 5'($urandom); in_a_address = 14'($urandom);
         in_a_mask = 4'($urandom); in_a_data = $urandom; in_a_corrupt = 1'($urandom);
         out_a_ready = 1'($urandom);
         out_d_valid = 1'($urandom); out_d_opcode = 3'($urandom); out_d_param = 2'($urandom);
         out_d_size = 3'($urandom); out_d_source = 5'($urandom); out_d_sink = 1'($urandom);
         out_d_denied = 1'($urandom); out_d_data = $urandom; out_d_corrupt = 1'($urandom);
         in_d_ready = 1'($urandom);
         #1;
         check("wire_a_valid", oa_valid[2], in_a_valid);
         check("wire_a_ready", ia_ready[2], out_a_ready);
         check("wire_a_payload",
               {oa_opcode[2], oa_param[2], oa_size[2], oa_source[2], oa_address[2],
                oa_mask[2], oa_data[2], oa_corrupt[2]},
               {in_a_opcode, in_a_param, in_a_size, in_a_source, in_a_address,
                in_a_mask, in_a_data, in_a_corrupt});
         check("wire_d_valid", id_valid[2], out_d_valid);
         check("wire_d_ready", od_ready[2], in_d_ready);
         check("wire_d_payload",
               {id_opcode[2], id_param[2], id_size[2], id_source[2], id_sink[2],
                id_denied[2], id_data[2], id_corrupt[2]},
               {out_d_opcode, out_d_param, out_d_size, out_d_source, out_d_sink,
                out_d_denied, out_d_data, out_d_corrupt});
         check("wire_counts", {a_cnt[2], d_cnt[2], busy[2]}, 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
